// File: rtl/dmem_io_bridge_if.sv
// Bus between the core's MEM stage and dmem_io_bridge: load/store port plus GPIO and TX drain signals.
interface dmem_io_bridge_if;
  logic [31:0] addr;
  logic        dmem_write;
  logic [31:0] dmem_write_data;
  logic [31:0] dmem_read_data;
  logic [15:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_drop;

  modport master (
    output addr, dmem_write, dmem_write_data, tx_ready,
    input  dmem_read_data, gpio_out, tx_data, tx_valid, tx_drop
  );

  modport slave (
    input  addr, dmem_write, dmem_write_data, tx_ready,
    output dmem_read_data, gpio_out, tx_data, tx_valid, tx_drop
  );
endinterface

// File: rtl/dmem_io_bridge.sv
// MEM-stage data bridge: word RAM plus GPIO, byte TX queue and cycle counter in the 0xFFFF_xxxx I/O page.
// Define DMEM_IO_CYCLE_COUNTER_EN to implement the CYCLES counter; otherwise CYCLES reads as zero.
module dmem_io_bridge #(
  parameter int DMEM_WORDS = 64,
  parameter int TXQ_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_io_bridge_if.slave bus
);
  localparam int AW = $clog2(DMEM_WORDS);
  localparam int QW = $clog2(TXQ_DEPTH);
  localparam int CW = QW + 1;

  typedef enum logic [7:0] {
    REG_GPIO   = 8'h00,
    REG_TXDATA = 8'h04,
    REG_TXSTAT = 8'h08,
    REG_CYCLES = 8'h0C
  } io_reg_e;

  logic          io_sel;
  logic          wr_en;
  logic          io_wr;
  logic [7:0]    io_off;
  logic [AW-1:0] ram_idx;
  logic          unused_addr;

  assign io_sel      = (bus.addr[31:16] == 16'hFFFF);
  assign io_off      = bus.addr[7:0];
  assign ram_idx     = bus.addr[AW+1:2];
  assign wr_en       = reset & bus.dmem_write;
  assign io_wr       = wr_en & io_sel;
  assign unused_addr = ^bus.addr[15:0];

  // ---------------- data RAM ----------------
  logic [31:0] ram_mem [DMEM_WORDS];

  // NOTE: storage arrays have no reset branch, so they map onto plain RAM without a clear sequence.
  always_ff @(posedge clk) begin
    if (wr_en && !io_sel) ram_mem[ram_idx] <= bus.dmem_write_data;
  end

  // ---------------- transmit queue ----------------
  logic [7:0]    txq_mem [TXQ_DEPTH];
  logic [QW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   gpio_q, gpio_d;
  logic          full, empty, pop, push_req, push_ok, drop;

  assign full     = (cnt_q == CW'(TXQ_DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop      = ~empty & bus.tx_ready;
  assign push_req = io_wr & (io_off == REG_TXDATA);
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & ~push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) txq_mem[wr_q] <= bus.dmem_write_data[7:0];
  end

  // NOTE: every variable gets its default first, so no path through this block can infer a latch.
  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    gpio_d = gpio_q;
    if (pop)     rd_d = rd_q + QW'(1);
    if (push_ok) wr_d = wr_q + QW'(1);
    if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push_ok) cnt_d = cnt_q - CW'(1);
    if (drop) ovf_d = 1'b1;
    else if (io_wr && io_off == REG_TXSTAT && bus.dmem_write_data[0]) ovf_d = 1'b0;
    if (io_wr && io_off == REG_GPIO) gpio_d = bus.dmem_write_data[15:0];
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      gpio_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      gpio_q <= gpio_d;
    end
  end

  // ---------------- cycle counter ----------------
  logic [31:0] cycles_rd;

`ifdef DMEM_IO_CYCLE_COUNTER_EN
  logic [31:0] cycles_q, cycles_d;

  // A store to CYCLES takes priority over that cycle's increment.
  always_comb begin
    cycles_d = cycles_q + 32'd1;
    if (io_wr && io_off == REG_CYCLES) cycles_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) cycles_q <= '0;
    else        cycles_q <= cycles_d;
  end

  assign cycles_rd = cycles_q;
`else
  assign cycles_rd = '0;
`endif

  // ---------------- load path and outputs ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (!io_sel) begin
      rdata = ram_mem[ram_idx];
    end else begin
      case (io_off)
        REG_GPIO:   rdata = {16'h0, gpio_q};
        REG_TXDATA: rdata = {24'h0, txq_mem[rd_q]};
        REG_TXSTAT: rdata = {16'h0, 8'(cnt_q), 5'h0, ovf_q, full, empty};
        REG_CYCLES: rdata = cycles_rd;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.dmem_read_data = rdata;
  assign bus.gpio_out       = gpio_q;
  assign bus.tx_data        = txq_mem[rd_q];
  assign bus.tx_valid       = ~empty;
  assign bus.tx_drop        = drop;
endmodule

// File: tb/tb_dmem_io_bridge.sv
// Self-checking bench for dmem_io_bridge: directed stimulus, a queue-based reference model compared
// every cycle, and literal expectations from the reference scenarios.
module tb_dmem_io_bridge;
  localparam int DW = 64;
  localparam int TD = 4;
  localparam logic [31:0] A_GPIO = 32'hFFFF_0000;
  localparam logic [31:0] A_TXD  = 32'hFFFF_0004;
  localparam logic [31:0] A_TXS  = 32'hFFFF_0008;
  localparam logic [31:0] A_CYC  = 32'hFFFF_000C;
`ifdef DMEM_IO_CYCLE_COUNTER_EN
  localparam bit HAS_CYC = 1'b1;
`else
  localparam bit HAS_CYC = 1'b0;
`endif

  logic clk;
  logic reset;
  dmem_io_bridge_if bus ();

  dmem_io_bridge #(.DMEM_WORDS(DW), .TXQ_DEPTH(TD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [DW];
  bit          m_ram_v [DW];
  logic [7:0]  m_q [$];
  logic [15:0] m_gpio;
  bit          m_ovf;
  logic [31:0] m_cyc;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DW));
  endfunction

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
    v = '0;
    if (a[31:16] != 16'hFFFF) begin
      v = m_ram[widx(a)];
      return m_ram_v[widx(a)];
    end
    case (a[7:0])
      8'h00: v = {16'h0, m_gpio};
      8'h04: begin
        if (m_q.size() == 0) return 1'b0;
        v = {24'h0, m_q[0]};
      end
      8'h08: v = (32'(m_q.size()) << 8) | (32'(m_ovf) << 2) |
                 (32'(m_q.size() == TD) << 1) | 32'(m_q.size() == 0);
      8'h0C: v = HAS_CYC ? m_cyc : 32'h0;
      default: v = '0;
    endcase
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit io, pop, push, acc;
    io = (bus.addr[31:16] == 16'hFFFF);
    if (!reset) begin
      m_gpio = '0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_cyc  = '0;
    end else begin
      pop  = (m_q.size() > 0) && bus.tx_ready;
      push = bus.dmem_write && io && (bus.addr[7:0] == 8'h04);
      acc  = push && ((m_q.size() < TD) || pop);
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(bus.dmem_write_data[7:0]);
      if (push && !acc) m_ovf = 1'b1;
      if (bus.dmem_write && io && bus.addr[7:0] == 8'h00) m_gpio = bus.dmem_write_data[15:0];
      if (bus.dmem_write && io && bus.addr[7:0] == 8'h08 && bus.dmem_write_data[0]) m_ovf = 1'b0;
      if (bus.dmem_write && io && bus.addr[7:0] == 8'h0C) m_cyc = '0;
      else                                                m_cyc = m_cyc + 32'd1;
      if (bus.dmem_write && !io) begin
        m_ram[widx(bus.addr)]   = bus.dmem_write_data;
        m_ram_v[widx(bus.addr)] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ev;
    bit known, drop_exp;
    if (chk_en) begin
      known = m_read(bus.addr, ev);
      if (known) check("cmp_rdata", bus.dmem_read_data, ev);
      check("cmp_gpio", 32'(bus.gpio_out), 32'(m_gpio));
      check("cmp_tx_valid", 32'(bus.tx_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) check("cmp_tx_data", 32'(bus.tx_data), 32'(m_q[0]));
      drop_exp = reset && bus.dmem_write && (bus.addr[31:16] == 16'hFFFF) &&
                 (bus.addr[7:0] == 8'h04) && (m_q.size() == TD) && !bus.tx_ready;
      check("cmp_tx_drop", 32'(bus.tx_drop), 32'(drop_exp));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
    bus.addr            = a;
    bus.dmem_write      = we;
    bus.dmem_write_data = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, 1'b1, d);
    tick();
    drive(32'h0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(a, 1'b0, 32'h0);
    @(negedge clk);
    check(name, bus.dmem_read_data, exp);
    tick();
  endtask

  task automatic push(input logic [7:0] d, input logic exp_drop);
    drive(A_TXD, 1'b1, {24'h0, d});
    @(negedge clk);
    check("tx_drop_on_push", 32'(bus.tx_drop), 32'(exp_drop));
    tick();
    drive(32'h0, 1'b0, 32'h0);
  endtask

  task automatic drain(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] exp [4];
    exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_valid", 32'(bus.tx_valid), 32'h1);
      check("drain_data", 32'(bus.tx_data), 32'(exp[i]));
      tick();
    end
    @(negedge clk);
    check("drain_empty", 32'(bus.tx_valid), 32'h0);
    tick();
    bus.tx_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < DW; i++) m_ram_v[i] = 1'b0;
    reset        = 1'b0;
    bus.tx_ready = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_gpio", 32'(bus.gpio_out), 32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_drop", 32'(bus.tx_drop), 32'h0);
    tick();
    reset = 1'b1;

    // counter: ten edges after release
    repeat (10) tick();
    rd(A_CYC, HAS_CYC ? 32'd10 : 32'd0, "cyc_after_10");
    wr(A_CYC, 32'h0);
    rd(A_CYC, 32'd0, "cyc_cleared");
`ifdef DMEM_IO_CYCLE_COUNTER_EN
    dut.cycles_q = 32'hFFFF_FFFF;
    m_cyc        = 32'hFFFF_FFFF;
    rd(A_CYC, 32'hFFFF_FFFF, "cyc_forced");
    rd(A_CYC, 32'h0, "cyc_wrap");
`endif

    // RAM and aliasing
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
    wr(32'h10 + 4 * DW, 32'hCAFE_0001);
    rd(32'h10, 32'hCAFE_0001, "ram_alias");
    wr(32'h20, 32'h0000_0001);

    // GPIO, reset, writes ignored during reset
    wr(A_GPIO, 32'h1234_ABCD);
    @(negedge clk);
    check("gpio_out", 32'(bus.gpio_out), 32'h0000_ABCD);
    tick();
    rd(A_GPIO, 32'h0000_ABCD, "gpio_rd");
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("gpio_rst", 32'(bus.gpio_out), 32'h0);
    tick();
    wr(A_GPIO, 32'h0000_FFFF);
    wr(32'h20, 32'h5555_5555);
    @(negedge clk);
    check("gpio_wr_in_rst", 32'(bus.gpio_out), 32'h0);
    tick();
    reset = 1'b1;
    rd(32'h20, 32'h0000_0001, "ram_wr_in_rst");

    // unmapped I/O offset
    wr(32'hFFFF_0010, 32'hFFFF_FFFF);
    rd(32'hFFFF_0010, 32'h0, "unmapped");

    // queue fill with overflow, then drain
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i), 1'b0);
    push(8'h15, 1'b1);
    @(negedge clk);
    check("drop_one_cycle", 32'(bus.tx_drop), 32'h0);
    tick();
    rd(A_TXS, 32'h0000_0406, "txstat_full_ovf");
    drain(8'h11, 8'h12, 8'h13, 8'h14);

    // full queue: push and pop in the same cycle
    for (int i = 0; i < 4; i++) push(8'h21 + 8'(i), 1'b0);
    bus.tx_ready = 1'b1;
    push(8'hAA, 1'b0);
    bus.tx_ready = 1'b0;
    rd(A_TXS, 32'h0000_0406, "txstat_count4");
    drain(8'h22, 8'h23, 8'h24, 8'hAA);
    wr(A_TXS, 32'h1);
    rd(A_TXS, 32'h0000_0001, "ovf_cleared");

    // reset mid-drain
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), 1'b0);
    bus.tx_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
    check("mid_rst_drop", 32'(bus.tx_drop), 32'h0);
    tick();
    rd(A_TXS, 32'h0000_0001, "mid_rst_txstat");
    rd(32'h10, 32'hCAFE_0001, "ram_kept");
    reset        = 1'b1;
    bus.tx_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
